fetch_decode_latch: RTL
=======================

# fetch_decode_latch

Pipeline stage between the instruction memory and the decoder. It samples the 16-bit words fetched each cycle and assembles two-word instructions (opcode word plus 16-bit immediate) into one decoder-facing packet. It also holds its outputs under hazard stalls and squashes in-flight words on a taken jump. All outputs are registered, so the decoder sees a stable instruction for a full cycle.

## Interface
- PC_W, 32, width of the fetch PC carried alongside each instruction
- IMM_CODE, 2'b11, value of word[15:14] that marks a two-word (immediate-carrying) instruction
- NOP_WORD, 16'h0000, instruction word driven while no valid instruction is presented
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_word  in  16  instruction word from instruction memory
- in_valid  in  1  in_word is a newly fetched word this cycle
- in_pc  in  PC_W  address of in_word
- stall  in  1  hazard unit requests hold of decode stage
- flush  in  1  taken jump; discard all partial and presented instructions
- instr_out  out  16  opcode word to decoder
- imm_out  out  16  immediate word; 0 when has_imm=0
- has_imm  out  1  instr_out carries an immediate in imm_out
- pc_out  out  PC_W  address of the opcode word of the presented instruction
- valid_out  out  1  instr_out/imm_out/pc_out form a valid instruction this cycle
- fetch_hold  out  1  combinational; fetch must not advance PC this cycle
- issue_count  out  16  number of instructions presented (valid_out pulses), wraps

## Operation
- Two states: FIRST (expecting an opcode word), WAIT_IMM (opcode latched, expecting its immediate).
- Priority at each rising edge: rst > flush > stall > normal.
- rst: state=FIRST; instr_out=NOP_WORD; imm_out=0; has_imm=0; pc_out=0; valid_out=0; issue_count=0; hold registers cleared.
- flush: state=FIRST; valid_out=0; instr_out=NOP_WORD; has_imm=0; imm_out=0; any latched opcode is discarded. The in_word sampled in the same cycle is discarded. issue_count is unchanged.
- stall (no flush): all output registers and the state are held. in_word is ignored. fetch_hold=1.
- FIRST, in_valid=1, in_word[15:14]!=IMM_CODE: present at the next edge: instr_out=in_word, imm_out=0, has_imm=0, pc_out=in_pc, valid_out=1; issue_count+1; stay in FIRST.
- FIRST, in_valid=1, in_word[15:14]==IMM_CODE: latch in_word and in_pc into hold registers; valid_out=0, instr_out=NOP_WORD; go to WAIT_IMM.
- WAIT_IMM, in_valid=1: the word is treated as immediate regardless of its bits. Present instr_out=held opcode, imm_out=in_word, has_imm=1, pc_out=held pc, valid_out=1; issue_count+1; go to FIRST.
- Any state, in_valid=0 (no stall/flush): valid_out=0, instr_out=NOP_WORD; state and hold registers are retained.
- fetch_hold = stall & ~flush & ~rst.
- issue_count wraps from 16'hFFFF to 0.

## Timing
- Single-word latency: in_word sampled at edge N is presented during cycle N+1 (after edge N).
- Two-word latency: valid_out asserts after the edge that samples the immediate. No output for the opcode-word cycle.
- valid_out is a one-cycle pulse per instruction unless stall holds it. A stalled valid instruction stays presented and is counted once.
- Flush during WAIT_IMM: the partial instruction is lost, and the next accepted word is decoded as an opcode.
- Stall and flush together: flush wins, and fetch_hold=0 so fetch can load the jump target.
- rst during a stall or WAIT_IMM: the full reset state applies at that edge.

## Test plan
- Reset then single-word stream: rst 1 cycle. Feed 16'h1234@pc 0x20, then 16'h2345@0x21 -> valid_out pulses with instr_out=1234/pc 0x20, then 2345/pc 0x21. has_imm=0. issue_count=2.
- Two-word instruction: feed C005@0x22, then ABCD@0x23 -> no valid after the first edge. After the second edge: instr_out=C005, imm_out=ABCD, has_imm=1, pc_out=0x22.
- Stall hold: a presented 1234 with stall=1 for 3 cycles -> outputs frozen, fetch_hold=1, incoming words ignored, issue_count unchanged. On release, the next word is accepted.
- Flush mid-immediate: C005 accepted (WAIT_IMM), then flush=1 with in_word=ABCD -> valid_out=0. Next word 16'h0111 is presented as a single-word instruction, has_imm=0.
- Stall+flush same cycle: both high -> fetch_hold=0, valid_out=0, state=FIRST.
- Counter wrap: preload by issuing 65536 single-word instructions -> issue_count returns to 0.

Source files
------------

// File: rtl/fetch_decode_latch.sv
// rtl/fetch_decode_latch.sv - fetch/decode boundary latch: assembles opcode+immediate pairs, stall hold, jump squash
module fetch_decode_latch #(
    parameter int          PC_W     = 32,
    parameter logic [1:0]  IMM_CODE = 2'b11,
    parameter logic [15:0] NOP_WORD = 16'h0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [15:0]     in_word,
    input  logic            in_valid,
    input  logic [PC_W-1:0] in_pc,
    input  logic            stall,
    input  logic            flush,
    output logic [15:0]     instr_out,
    output logic [15:0]     imm_out,
    output logic            has_imm,
    output logic [PC_W-1:0] pc_out,
    output logic            valid_out,
    output logic            fetch_hold,
    output logic [15:0]     issue_count
);

    typedef enum logic {FIRST, WAIT_IMM} state_t;

    state_t          state, state_nxt;
    logic [15:0]     hold_word, hold_word_nxt;
    logic [PC_W-1:0] hold_pc, hold_pc_nxt;
    logic [15:0]     instr_nxt, imm_nxt, count_nxt;
    logic            has_imm_nxt, valid_nxt;
    logic [PC_W-1:0] pc_nxt;

    // Fetch may still advance under a stall+flush so it can load the jump target.
    assign fetch_hold = stall & ~flush & ~rst;

    always_comb begin
        state_nxt     = state;
        hold_word_nxt = hold_word;
        hold_pc_nxt   = hold_pc;
        instr_nxt     = instr_out;
        imm_nxt       = imm_out;
        has_imm_nxt   = has_imm;
        pc_nxt        = pc_out;
        valid_nxt     = valid_out;
        count_nxt     = issue_count;

        if (flush) begin
            state_nxt   = FIRST;
            valid_nxt   = 1'b0;
            instr_nxt   = NOP_WORD;
            has_imm_nxt = 1'b0;
            imm_nxt     = 16'h0000;
        end else if (stall) begin
            // everything held
        end else if (!in_valid) begin
            valid_nxt   = 1'b0;
            instr_nxt   = NOP_WORD;
            has_imm_nxt = 1'b0;
            imm_nxt     = 16'h0000;
        end else begin
            case (state)
                FIRST: begin
                    if (in_word[15:14] == IMM_CODE) begin
                        hold_word_nxt = in_word;
                        hold_pc_nxt   = in_pc;
                        valid_nxt     = 1'b0;
                        instr_nxt     = NOP_WORD;
                        has_imm_nxt   = 1'b0;
                        imm_nxt       = 16'h0000;
                        state_nxt     = WAIT_IMM;
                    end else begin
                        instr_nxt   = in_word;
                        imm_nxt     = 16'h0000;
                        has_imm_nxt = 1'b0;
                        pc_nxt      = in_pc;
                        valid_nxt   = 1'b1;
                        count_nxt   = issue_count + 16'd1;
                    end
                end
                WAIT_IMM: begin
                    // Second word is an immediate whatever its top bits say.
                    instr_nxt   = hold_word;
                    imm_nxt     = in_word;
                    has_imm_nxt = 1'b1;
                    pc_nxt      = hold_pc;
                    valid_nxt   = 1'b1;
                    count_nxt   = issue_count + 16'd1;
                    state_nxt   = FIRST;
                end
                default: state_nxt = FIRST;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FIRST;
            hold_word   <= 16'h0000;
            hold_pc     <= '0;
            instr_out   <= NOP_WORD;
            imm_out     <= 16'h0000;
            has_imm     <= 1'b0;
            pc_out      <= '0;
            valid_out   <= 1'b0;
            issue_count <= 16'h0000;
        end else begin
            state       <= state_nxt;
            hold_word   <= hold_word_nxt;
            hold_pc     <= hold_pc_nxt;
            instr_out   <= instr_nxt;
            imm_out     <= imm_nxt;
            has_imm     <= has_imm_nxt;
            pc_out      <= pc_nxt;
            valid_out   <= valid_nxt;
            issue_count <= count_nxt;
        end
    end

endmodule
